bw_io_impctl_upcntl: RTL and testbench



---
 rtl/bw_io_impctl_pkg.sv | 41 ++++
 rtl/bw_io_impctl_updn_ctr.sv | 131 +++++++++++++
 rtl/bw_io_impctl_upcntl.sv | 188 ++++++++++++++++++
 tb/tb_bw_io_impctl_upcntl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_io_impctl_pkg.sv
// ---------------------------------------------------------------------------
// bw_io_impctl_pkg
// Shared types and default constants for the pull-up impedance-control
// calibration loop (bw_io_impctl_upcntl and its up/down code counter).
//   state_t : calibration FSM states
//   dir_t   : code step direction (UP = stronger pull-up, DN = weaker)
//   DEF_*   : default parameter values for the loop
//   cnt_width(): bit width needed to hold a counter value 0..max_val
// ---------------------------------------------------------------------------
package bw_io_impctl_pkg;

    localparam int                CODE_W            = 8;
    localparam logic [CODE_W-1:0] DEF_INIT_CODE     = 8'h80;
    localparam int                DEF_SETTLE_CYC    = 16;
    localparam int                DEF_SCLK_LAT      = 3;
    localparam int                DEF_FILT_CNT      = 4;
    localparam int                DEF_LOCK_TOGGLES  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_STROBE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_EVAL    = 3'd4
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    // Width of a counter that must represent every value 0..max_val.
    // Never returns less than one bit so degenerate parameters still elaborate.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bw_io_impctl_updn_ctr.sv
// ---------------------------------------------------------------------------
// bw_io_impctl_updn_ctr
// Saturating up/down register holding the pull-up drive code, plus the
// saturation flags and the reversal counter that decides lock.
//
// Ports:
//   clk      in   core clock
//   reset    in   synchronous active-high reset
//   clr      in   calibration disabled: clear toggles, lock and sat flags
//                 (code and last step direction are held)
//   step     in   one-cycle request to move the code by one LSB
//   dir      in   direction of the requested step
//   freeze   in   suppress the requested step entirely
//   code     out  registered drive code
//   upd      out  one-cycle pulse in the first cycle a new code is visible
//   sat_hi   out  last blocked step was UP at all-ones
//   sat_lo   out  last blocked step was DN at zero
//   locked   out  LOCK_TOGGLES consecutive reversals seen (sticky)
// ---------------------------------------------------------------------------
module bw_io_impctl_updn_ctr
    import bw_io_impctl_pkg::*;
#(
    parameter int               WIDTH        = CODE_W,
    parameter logic [WIDTH-1:0] INIT_CODE    = DEF_INIT_CODE,
    parameter int               LOCK_TOGGLES = DEF_LOCK_TOGGLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             step,
    input  dir_t             dir,
    input  logic             freeze,
    output logic [WIDTH-1:0] code,
    output logic             upd,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             locked
);

    localparam int TOG_W = cnt_width(LOCK_TOGGLES);
    localparam logic [TOG_W-1:0] TOG_MAX = TOG_W'(LOCK_TOGGLES);

    logic [WIDTH-1:0] code_q,   code_d;
    logic             upd_q,    upd_d;
    logic             sat_hi_q, sat_hi_d;
    logic             sat_lo_q, sat_lo_d;
    logic             locked_q, locked_d;
    logic [TOG_W-1:0] tog_q,    tog_d;
    dir_t             last_step_dir_q, last_step_dir_d;

    logic at_max;
    logic at_min;

    assign at_max = (code_q == {WIDTH{1'b1}});
    assign at_min = (code_q == {WIDTH{1'b0}});

    always_comb begin
        code_d          = code_q;
        upd_d           = 1'b0;
        sat_hi_d        = sat_hi_q;
        sat_lo_d        = sat_lo_q;
        locked_d        = locked_q;
        tog_d           = tog_q;
        last_step_dir_d = last_step_dir_q;

        if (clr) begin
            tog_d    = '0;
            locked_d = 1'b0;
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
        end else if (step && !freeze) begin
            if ((dir == DIR_UP) && at_max) begin
                // Blocked at the top rail: no code change, reversal history kept.
                sat_hi_d = 1'b1;
            end else if ((dir == DIR_DN) && at_min) begin
                sat_lo_d = 1'b1;
            end else begin
                if (dir == DIR_UP) begin
                    code_d = code_q + WIDTH'(1);
                end else begin
                    code_d = code_q - WIDTH'(1);
                end
                upd_d    = 1'b1;
                sat_hi_d = 1'b0;
                sat_lo_d = 1'b0;

                // A dithering loop reverses on every applied step; any repeat
                // in the same direction means the loop is still slewing.
                if (dir != last_step_dir_q) begin
                    if (tog_q != TOG_MAX) begin
                        tog_d = tog_q + TOG_W'(1);
                    end
                end else begin
                    tog_d = '0;
                end
                last_step_dir_d = dir;

                if (tog_d == TOG_MAX) begin
                    locked_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q          <= INIT_CODE;
            upd_q           <= 1'b0;
            sat_hi_q        <= 1'b0;
            sat_lo_q        <= 1'b0;
            locked_q        <= 1'b0;
            tog_q           <= '0;
            last_step_dir_q <= DIR_UP;
        end else begin
            code_q          <= code_d;
            upd_q           <= upd_d;
            sat_hi_q        <= sat_hi_d;
            sat_lo_q        <= sat_lo_d;
            locked_q        <= locked_d;
            tog_q           <= tog_d;
            last_step_dir_q <= last_step_dir_d;
        end
    end

    assign code   = code_q;
    assign upd    = upd_q;
    assign sat_hi = sat_hi_q;
    assign sat_lo = sat_lo_q;
    assign locked = locked_q;

endmodule

// File: rtl/bw_io_impctl_upcntl.sv
// ---------------------------------------------------------------------------
// bw_io_impctl_upcntl
// Closed-loop calibration controller for the pull-up impedance leg. Each
// iteration waits for the pad to settle, strobes the calibration cell,
// waits for the synchronised comparator result and evaluates it. A
// consecutive-vote filter turns FILT_CNT agreeing evaluations into one code
// step; the code counter reports saturation and lock.
//
// Ports:
//   clk      in   core clock
//   reset    in   synchronous active-high reset
//   cal_en   in   enable the loop; low returns to IDLE and clears status
//   freeze   in   suppress code steps while sampling continues
//   above    in   registered comparator result (1 = pad above vref)
//   sclk     out  one-cycle sample strobe to the calibration cell
//   cbu      out  registered pull-up drive code, [WIDTH:1] indexing
//   cbu_upd  out  pulse in the first cycle a new cbu value is visible
//   locked   out  loop converged (sticky until reset or cal_en low)
//   sat_hi   out  an UP step was blocked at all-ones
//   sat_lo   out  a DN step was blocked at zero
// ---------------------------------------------------------------------------
module bw_io_impctl_upcntl
    import bw_io_impctl_pkg::*;
#(
    parameter int               WIDTH        = CODE_W,
    parameter logic [WIDTH-1:0] INIT_CODE    = DEF_INIT_CODE,
    parameter int               SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int               SCLK_LAT     = DEF_SCLK_LAT,
    parameter int               FILT_CNT     = DEF_FILT_CNT,
    parameter int               LOCK_TOGGLES = DEF_LOCK_TOGGLES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cal_en,
    input  logic           freeze,
    input  logic           above,
    output logic           sclk,
    output logic [WIDTH:1] cbu,
    output logic           cbu_upd,
    output logic           locked,
    output logic           sat_hi,
    output logic           sat_lo
);

    // One timer serves both SETTLE and CAPTURE, so size it for the longer.
    localparam int TMR_MAX = (SETTLE_CYC > SCLK_LAT) ? SETTLE_CYC : SCLK_LAT;
    localparam int TMR_W   = cnt_width(TMR_MAX);
    localparam int FILT_W  = cnt_width(FILT_CNT);

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  CAPT_LAST   = TMR_W'(SCLK_LAT - 1);
    localparam logic [FILT_W-1:0] FILT_TGT    = FILT_W'(FILT_CNT);

    state_t            state_q,    state_d;
    logic [TMR_W-1:0]  tmr_q,      tmr_d;
    logic [FILT_W-1:0] filt_q,     filt_d;
    dir_t              last_dir_q, last_dir_d;
    logic              sclk_q,     sclk_d;

    logic              step_req;
    dir_t              step_dir;
    logic              ctr_clr;
    dir_t              cur_dir;
    logic [FILT_W-1:0] filt_nx;

    logic [WIDTH-1:0]  code;

    // Next-state, timer and vote filter.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        filt_d     = filt_q;
        last_dir_d = last_dir_q;
        step_req   = 1'b0;
        step_dir   = DIR_UP;
        ctr_clr    = 1'b0;
        filt_nx    = filt_q;
        // Stronger pull-up raises the pad, so move away from the comparator.
        cur_dir    = above ? DIR_DN : DIR_UP;

        if (!cal_en) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
            filt_d  = '0;
            ctr_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end

                ST_SETTLE: begin
                    if (tmr_q == SETTLE_LAST) begin
                        state_d = ST_STROBE;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end

                ST_STROBE: begin
                    state_d = ST_CAPTURE;
                    tmr_d   = '0;
                end

                ST_CAPTURE: begin
                    if (tmr_q == CAPT_LAST) begin
                        state_d = ST_EVAL;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end

                ST_EVAL: begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;

                    // A vote in a new direction (or the first vote after a
                    // step) restarts the run at one.
                    if ((cur_dir == last_dir_q) && (filt_q != '0)) begin
                        filt_nx = filt_q + FILT_W'(1);
                    end else begin
                        filt_nx    = FILT_W'(1);
                        last_dir_d = cur_dir;
                    end

                    // The filter clears on a full run even when the step is
                    // frozen or blocked, so each step needs a fresh run.
                    if (filt_nx == FILT_TGT) begin
                        step_req = 1'b1;
                        step_dir = cur_dir;
                        filt_d   = '0;
                    end else begin
                        filt_d = filt_nx;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end

        // Registered strobe: high exactly for the cycle spent in STROBE.
        sclk_d = (state_d == ST_STROBE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            filt_q     <= '0;
            last_dir_q <= DIR_UP;
            sclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            filt_q     <= filt_d;
            last_dir_q <= last_dir_d;
            sclk_q     <= sclk_d;
        end
    end

    bw_io_impctl_updn_ctr #(
        .WIDTH        (WIDTH),
        .INIT_CODE    (INIT_CODE),
        .LOCK_TOGGLES (LOCK_TOGGLES)
    ) u_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (ctr_clr),
        .step   (step_req),
        .dir    (step_dir),
        .freeze (freeze),
        .code   (code),
        .upd    (cbu_upd),
        .sat_hi (sat_hi),
        .sat_lo (sat_lo),
        .locked (locked)
    );

    assign cbu  = code;
    assign sclk = sclk_q;

endmodule

// File: tb/tb_bw_io_impctl_upcntl.sv
// ---------------------------------------------------------------------------
// tb_bw_io_impctl_upcntl
// Directed bench for the pull-up calibration controller. Instance A uses the
// default INIT_CODE (0x80); instance B starts at 0xFF for the top rail.
// Expected code updates are queued by the stimulus; a forked monitor pops
// one entry per cbu_upd pulse and checks code, evaluation index and latency.
// ---------------------------------------------------------------------------
module tb_bw_io_impctl_upcntl;
    import bw_io_impctl_pkg::*;

    localparam int ITER    = DEF_SETTLE_CYC + 1 + DEF_SCLK_LAT + 1;  // 21
    localparam int UPD_LAT = DEF_SCLK_LAT + 2;                       // strobe -> cbu_upd

    typedef struct {
        logic [7:0] code;
        int         idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       cal_en_a = 1'b0, freeze_a = 1'b0, above_a;
    logic       sclk_a, upd_a, locked_a, sat_hi_a, sat_lo_a;
    logic [8:1] cbu_a;

    logic       cal_en_b = 1'b0, freeze_b = 1'b0, above_b = 1'b0;
    logic       sclk_b, upd_b, locked_b, sat_hi_b, sat_lo_b;
    logic [8:1] cbu_b;

    // Cell model for A: 0 = constant, 1 = alternate per strobe, 2 = threshold.
    int         mode_a = 0;
    logic       const_a = 1'b0;
    logic       alt_a = 1'b0;
    logic [7:0] thresh_a = 8'h85;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int sclk_tot[2];
    int last_sclk[2];
    int sclk_gap[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        above_a = const_a;
        case (mode_a)
            1:       above_a = alt_a;
            2:       above_a = (cbu_a >= thresh_a);
            default: above_a = const_a;
        endcase
    end

    bw_io_impctl_upcntl u_dut_a (
        .clk     (clk),
        .reset   (reset),
        .cal_en  (cal_en_a),
        .freeze  (freeze_a),
        .above   (above_a),
        .sclk    (sclk_a),
        .cbu     (cbu_a),
        .cbu_upd (upd_a),
        .locked  (locked_a),
        .sat_hi  (sat_hi_a),
        .sat_lo  (sat_lo_a)
    );

    bw_io_impctl_upcntl #(.INIT_CODE(8'hFF)) u_dut_b (
        .clk     (clk),
        .reset   (reset),
        .cal_en  (cal_en_b),
        .freeze  (freeze_b),
        .above   (above_b),
        .sclk    (sclk_b),
        .cbu     (cbu_b),
        .cbu_upd (upd_b),
        .locked  (locked_b),
        .sat_hi  (sat_hi_b),
        .sat_lo  (sat_lo_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, got, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sclk_a) begin
                sclk_gap[0]  = cyc - last_sclk[0];
                last_sclk[0] = cyc;
                sclk_tot[0]++;
                alt_a = ~alt_a;
            end
            if (sclk_b) begin
                sclk_gap[1]  = cyc - last_sclk[1];
                last_sclk[1] = cyc;
                sclk_tot[1]++;
            end
            if (upd_a) begin
                if (q_a.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL a_spurious_upd: cbu=0x%0h, required no update (cycle %0d)", cbu_a, cyc);
                end else begin
                    e = q_a.pop_front();
                    chk("a_upd_code", cbu_a, e.code);
                    chk("a_upd_eval_idx", sclk_tot[0], e.idx);
                    chk("a_upd_latency", cyc - last_sclk[0], UPD_LAT);
                end
            end
            if (upd_b) begin
                if (q_b.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL b_spurious_upd: cbu=0x%0h, required no update (cycle %0d)", cbu_b, cyc);
                end else begin
                    e = q_b.pop_front();
                    chk("b_upd_code", cbu_b, e.code);
                    chk("b_upd_eval_idx", sclk_tot[1], e.idx);
                    chk("b_upd_latency", cyc - last_sclk[1], UPD_LAT);
                end
            end
        end
    endtask

    task automatic push_a(input logic [7:0] code, input int idx);
        exp_t e;
        e.code = code;
        e.idx  = idx;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] code, input int idx);
        exp_t e;
        e.code = code;
        e.idx  = idx;
        q_b.push_back(e);
    endtask

    // Wait until instance k has issued `target` strobes, then let the EVAL and
    // any resulting cbu_upd pass before returning at a negedge.
    task automatic wait_evals(input int k, input int target, input string name);
        int b = 0;
        while (sclk_tot[k] < target) begin
            @(posedge clk);
            b++;
            if (b > 3000) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: timeout waiting for strobe %0d, seen %0d", name, target, sclk_tot[k]);
                break;
            end
        end
        repeat (UPD_LAT + 1) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        cal_en_a = 1'b0;
        cal_en_b = 1'b0;
        freeze_a = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q_a.delete();
        q_b.delete();
    endtask

    initial begin
        int base;
        int held;
        logic [7:0] seq [9];

        for (int i = 0; i < 2; i++) begin
            sclk_tot[i]  = 0;
            last_sclk[i] = 0;
            sclk_gap[i]  = 0;
        end
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_a_cbu", cbu_a, 8'h80);
        chk("rst_a_sclk", sclk_a, 0);
        chk("rst_a_upd", upd_a, 0);
        chk("rst_a_locked", locked_a, 0);
        chk("rst_a_sat_hi", sat_hi_a, 0);
        chk("rst_a_sat_lo", sat_lo_a, 0);
        chk("rst_b_cbu", cbu_b, 8'hFF);

        // Constant above=0: step up after every 4th evaluation
        base = sclk_tot[0];
        mode_a = 0;
        const_a = 1'b0;
        push_a(8'h81, base + 4);
        push_a(8'h82, base + 8);
        cal_en_a = 1'b1;
        wait_evals(0, base + 8, "climb");
        chk("climb_sclk_period", sclk_gap[0], ITER);
        chk("climb_cbu", cbu_a, 8'h82);
        chk("climb_queue_empty", q_a.size(), 0);

        // Alternating comparator: filter never fills
        do_reset();
        mode_a = 1;
        base = sclk_tot[0];
        cal_en_a = 1'b1;
        wait_evals(0, base + 8, "alternate");
        chk("alt_cbu_held", cbu_a, 8'h80);
        chk("alt_queue_empty", q_a.size(), 0);

        // Threshold cell at 0x85: climb then dither 0x84/0x85 until lock
        do_reset();
        mode_a = 2;
        thresh_a = 8'h85;
        base = sclk_tot[0];
        seq = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h84, 8'h85, 8'h84, 8'h85};
        for (int i = 0; i < 9; i++) push_a(seq[i], base + 4 * (i + 1));
        cal_en_a = 1'b1;
        wait_evals(0, base + 32, "lock_pre");
        chk("lock_pre_locked", locked_a, 0);
        wait_evals(0, base + 36, "lock");
        chk("lock_locked", locked_a, 1);
        chk("lock_cbu", cbu_a, 8'h85);
        chk("lock_queue_empty", q_a.size(), 0);

        // Freeze: votes still clear the filter but no step is applied
        do_reset();
        mode_a = 0;
        const_a = 1'b0;
        freeze_a = 1'b1;
        base = sclk_tot[0];
        cal_en_a = 1'b1;
        wait_evals(0, base + 8, "freeze");
        chk("freeze_cbu_held", cbu_a, 8'h80);
        freeze_a = 1'b0;
        push_a(8'h81, base + 12);
        wait_evals(0, base + 12, "unfreeze");
        chk("unfreeze_cbu", cbu_a, 8'h81);
        chk("unfreeze_queue_empty", q_a.size(), 0);

        // Threshold at 0x84: lock with the code left at 0x83, then drop cal_en
        do_reset();
        mode_a = 2;
        thresh_a = 8'h84;
        base = sclk_tot[0];
        seq = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h83, 8'h84, 8'h83, 8'h84, 8'h83};
        for (int i = 0; i < 9; i++) push_a(seq[i], base + 4 * (i + 1));
        cal_en_a = 1'b1;
        wait_evals(0, base + 36, "lock83");
        chk("lock83_cbu", cbu_a, 8'h83);
        chk("lock83_locked", locked_a, 1);
        begin
            int b = 0;
            while (sclk_tot[0] < base + 37 && b < 100) begin
                @(posedge clk);
                b++;
            end
            chk("drop_strobe_seen", sclk_tot[0], base + 37);
        end
        @(posedge clk);
        #1 cal_en_a = 1'b0;   // second CAPTURE cycle
        @(posedge clk);
        @(negedge clk);
        chk("drop_sclk", sclk_a, 0);
        chk("drop_cbu", cbu_a, 8'h83);
        chk("drop_locked", locked_a, 0);
        held = sclk_tot[0];
        repeat (2 * ITER) @(posedge clk);
        @(negedge clk);
        chk("drop_idle_no_strobe", sclk_tot[0], held);

        // Reset while in SETTLE
        @(posedge clk);
        #1 cal_en_a = 1'b1;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_cbu", cbu_a, 8'h80);
        chk("midrst_flags", {27'd0, sclk_a, upd_a, locked_a, sat_hi_a, sat_lo_a}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cal_en_a = 1'b0;
        chk("midrst_queue_empty", q_a.size(), 0);

        // Instance B at 0xFF: blocked UP step, then a DN step clears sat_hi
        base = sclk_tot[1];
        above_b = 1'b0;
        cal_en_b = 1'b1;
        wait_evals(1, base + 4, "sat");
        chk("sat_b_cbu", cbu_b, 8'hFF);
        chk("sat_b_sat_hi", sat_hi_b, 1);
        chk("sat_b_sat_lo", sat_lo_b, 0);
        above_b = 1'b1;
        push_b(8'hFE, base + 8);
        wait_evals(1, base + 8, "desat");
        chk("desat_b_cbu", cbu_b, 8'hFE);
        chk("desat_b_sat_hi", sat_hi_b, 0);
        chk("desat_b_queue_empty", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
